// File: rtl/iltype_instr_decoder.sv
// iltype_instr_decoder: RV32I I-type decoder (ALU-imm/load) feeding a DEPTH-entry FIFO of decoded fields
// Ports: clk; reset (sync, active-low); push side in_valid/in_ready/in_instr;
//   pop side out_valid/out_ready with head fields out_is_alu/out_is_load/out_illegal/out_rd/out_rs1/out_funct3/out_imm;
//   alu_count/load_count/illegal_count saturating retired-class counters, live only when ILTYPE_DEC_STATS_EN is defined (else 0).
module iltype_instr_decoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_alu,
  output logic        out_is_load,
  output logic        out_illegal,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [2:0]  out_funct3,
  output logic [31:0] out_imm,
  output logic [15:0] alu_count,
  output logic [15:0] load_count,
  output logic [15:0] illegal_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic        is_alu;
    logic        is_load;
    logic        illegal;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } entry_t;
  entry_t mem [DEPTH];
  entry_t dec, head;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [6:0] opcode, hi7;
  logic full, push, pop;
  assign opcode = in_instr[6:0];
  assign hi7 = in_instr[31:25];
  always_comb begin
    dec.is_alu = opcode == 7'b0010011;
    dec.is_load = opcode == 7'b0000011;
    dec.rd = in_instr[11:7];
    dec.rs1 = in_instr[19:15];
    dec.funct3 = in_instr[14:12];
    dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
    // shifts constrain imm[11:5]; loads reject funct3 3, 6 and 7
    dec.illegal = dec.is_alu ? (dec.funct3 == 3'd1 && hi7 != 7'b0) ||
                               (dec.funct3 == 3'd5 && hi7 != 7'b0 && hi7 != 7'b0100000)
                : dec.is_load ? (dec.funct3 == 3'd3 || dec.funct3[2:1] == 2'b11)
                : 1'b1;
  end
  assign out_valid = count != '0;
  assign full = count == CW'(DEPTH);
  assign in_ready = !full || out_ready;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign head = mem[rptr];
  // empty FIFO presents zeroed fields so stale slots never leak out
  assign out_is_alu = out_valid && head.is_alu;
  assign out_is_load = out_valid && head.is_load;
  assign out_illegal = out_valid && head.illegal;
  assign out_rd = out_valid ? head.rd : '0;
  assign out_rs1 = out_valid ? head.rs1 : '0;
  assign out_funct3 = out_valid ? head.funct3 : '0;
  assign out_imm = out_valid ? head.imm : '0;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= dec;
  always_ff @(posedge clk)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
`ifdef ILTYPE_DEC_STATS_EN
  always_ff @(posedge clk)
    if (!reset) begin
      alu_count <= '0;
      load_count <= '0;
      illegal_count <= '0;
    end else if (pop) begin
      if (head.illegal) illegal_count <= illegal_count + 16'(illegal_count != 16'hFFFF);
      else if (head.is_alu) alu_count <= alu_count + 16'(alu_count != 16'hFFFF);
      else if (head.is_load) load_count <= load_count + 16'(load_count != 16'hFFFF);
    end
`else
  assign alu_count = '0;
  assign load_count = '0;
  assign illegal_count = '0;
`endif
endmodule

// File: tb/tb_iltype_instr_decoder.sv
// tb_iltype_instr_decoder: randomized and directed checks of iltype_instr_decoder against a queue-based model
module tb_iltype_instr_decoder;
  localparam int DEPTH = 4;
`ifdef ILTYPE_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic in_ready, out_valid, out_is_alu, out_is_load, out_illegal;
  logic [4:0] out_rd, out_rs1;
  logic [2:0] out_funct3;
  logic [31:0] out_imm;
  logic [15:0] alu_count, load_count, illegal_count;
  typedef struct packed {
    bit alu, ld, ill;
    bit [4:0] rd, rs1;
    bit [2:0] f3;
    bit [31:0] imm;
  } ent_t;
  ent_t q[$];
  int vectors = 0, errors = 0;
  int m_alu = 0, m_ld = 0, m_ill = 0;

  iltype_instr_decoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_alu(out_is_alu), .out_is_load(out_is_load),
    .out_illegal(out_illegal), .out_rd(out_rd), .out_rs1(out_rs1), .out_funct3(out_funct3),
    .out_imm(out_imm), .alu_count(alu_count), .load_count(load_count), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  function automatic ent_t ref_decode(input logic [31:0] w);
    ent_t e;
    int f3, top7;
    f3 = int'(w[14:12]);
    top7 = int'(w[31:25]);
    e.alu = w[6:0] == 7'h13;
    e.ld = w[6:0] == 7'h03;
    e.rd = w[11:7];
    e.rs1 = w[19:15];
    e.f3 = w[14:12];
    e.imm = 32'($signed(w) >>> 20);
    if (e.alu) e.ill = (f3 == 1 && top7 != 0) || (f3 == 5 && !(top7 inside {0, 32}));
    else if (e.ld) e.ill = f3 inside {3, 6, 7};
    else e.ill = 1'b1;
    return e;
  endfunction

  function automatic int sat(input int x);
    return x < 65535 ? x + 1 : 65535;
  endfunction

  task automatic drive(input bit v, input logic [31:0] w, input bit r);
    @(negedge clk);
    in_valid = v;
    in_instr = w;
    out_ready = r;
    #1;
  endtask

  task automatic advance();
    bit push, pop;
    ent_t e;
    push = in_valid && (q.size() < DEPTH || out_ready);
    pop = out_ready && q.size() != 0;
    @(posedge clk);
    if (pop) begin
      e = q.pop_front();
      if (STATS) begin
        if (e.ill) m_ill = sat(m_ill);
        else if (e.alu) m_alu = sat(m_alu);
        else if (e.ld) m_ld = sat(m_ld);
      end
    end
    if (push) q.push_back(ref_decode(in_instr));
  endtask

  task automatic apply_reset(input bit v);
    @(negedge clk);
    reset = 1'b0;
    in_valid = v;
    in_instr = 32'h00000093;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    q.delete();
    m_alu = 0;
    m_ld = 0;
    m_ill = 0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    vectors++;
    if ({out_is_alu, out_is_load, out_illegal, out_imm} !== 35'd0) begin
      errors++;
      $display("FAIL reset_fields: alu=%b load=%b ill=%b imm=%h, want all 0", out_is_alu, out_is_load, out_illegal, out_imm);
    end
    vectors++;
    if ({alu_count, load_count, illegal_count} !== 48'd0) begin
      errors++;
      $display("FAIL reset_counters: %0d %0d %0d, want 0 0 0", alu_count, load_count, illegal_count);
    end
  endtask

  task automatic test_alu();
    drive(1'b1, 32'h00000013, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL alu_no_passthrough: out_valid=%b, want 0", out_valid);
    end
    advance();
    drive(1'b0, 32'h0, 1'b1);
    vectors++;
    if ({out_valid, out_is_alu, out_illegal, out_rd, out_rs1, out_imm} !== {1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'd0}) begin
      errors++;
      $display("FAIL alu_head: valid=%b alu=%b ill=%b rd=%0d rs1=%0d imm=%h, want 1 1 0 0 0 00000000",
               out_valid, out_is_alu, out_illegal, out_rd, out_rs1, out_imm);
    end
    advance();
    drive(1'b0, 32'h0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || alu_count !== (STATS ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL alu_count: valid=%b count=%0d, want 0 %0d", out_valid, alu_count, STATS ? 1 : 0);
    end
  endtask

  task automatic test_load();
    drive(1'b1, 32'hFFF2A083, 1'b0);
    advance();
    drive(1'b0, 32'h0, 1'b0);
    vectors++;
    if ({out_is_load, out_is_alu, out_illegal, out_rs1, out_funct3, out_rd, out_imm} !==
        {1'b1, 1'b0, 1'b0, 5'd5, 3'd2, 5'd1, 32'hFFFFFFFF}) begin
      errors++;
      $display("FAIL load_head: ld=%b alu=%b ill=%b rs1=%0d f3=%0d rd=%0d imm=%h, want 1 0 0 5 2 1 ffffffff",
               out_is_load, out_is_alu, out_illegal, out_rs1, out_funct3, out_rd, out_imm);
    end
    drive(1'b0, 32'h0, 1'b1);
    advance();
  endtask

  task automatic test_shift();
    drive(1'b1, 32'h02009093, 1'b0);
    advance();
    drive(1'b1, 32'h4030D093, 1'b0);
    advance();
    drive(1'b0, 32'h0, 1'b0);
    vectors++;
    if ({out_illegal, out_is_alu} !== 2'b11) begin
      errors++;
      $display("FAIL slli_bad: ill=%b alu=%b, want 1 1", out_illegal, out_is_alu);
    end
    drive(1'b0, 32'h0, 1'b1);
    advance();
    drive(1'b0, 32'h0, 1'b0);
    vectors++;
    if ({out_valid, out_illegal, out_is_alu, out_imm} !== {1'b1, 1'b0, 1'b1, 32'h00000403}) begin
      errors++;
      $display("FAIL srai_ok: valid=%b ill=%b alu=%b imm=%h, want 1 0 1 00000403", out_valid, out_illegal, out_is_alu, out_imm);
    end
    drive(1'b0, 32'h0, 1'b1);
    advance();
    drive(1'b0, 32'h0, 1'b0);
    vectors++;
    if ({alu_count, load_count, illegal_count} !== (STATS ? {16'd2, 16'd1, 16'd1} : 48'd0)) begin
      errors++;
      $display("FAIL shift_counts: alu=%0d load=%0d ill=%0d, want %0d %0d %0d",
               alu_count, load_count, illegal_count, STATS ? 2 : 0, STATS ? 1 : 0, STATS ? 1 : 0);
    end
  endtask

  task automatic test_illegal_opcodes();
    drive(1'b1, 32'h0000700F, 1'b0);
    advance();
    drive(1'b1, 32'h00003003, 1'b0);
    advance();
    drive(1'b0, 32'h0, 1'b0);
    vectors++;
    if ({out_illegal, out_is_alu, out_is_load} !== 3'b100) begin
      errors++;
      $display("FAIL fence_ill: ill=%b alu=%b ld=%b, want 1 0 0", out_illegal, out_is_alu, out_is_load);
    end
    drive(1'b0, 32'h0, 1'b1);
    advance();
    drive(1'b0, 32'h0, 1'b0);
    vectors++;
    if ({out_illegal, out_is_alu, out_is_load} !== 3'b101) begin
      errors++;
      $display("FAIL ld_f3_ill: ill=%b alu=%b ld=%b, want 1 0 1", out_illegal, out_is_alu, out_is_load);
    end
    drive(1'b0, 32'h0, 1'b1);
    advance();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h13 | (32'(i) << 7), 1'b0);
      vectors++;
      if (in_ready !== (i < DEPTH)) begin
        errors++;
        $display("FAIL fill_ready[%0d]: in_ready=%b, want %b", i, in_ready, i < DEPTH);
      end
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h13 | (32'(i + 8) << 7), 1'b1);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_rd !== 5'(i)) begin
        errors++;
        $display("FAIL full_pushpop[%0d]: in_ready=%b valid=%b rd=%0d, want 1 1 %0d", i, in_ready, out_valid, out_rd, i);
      end
      advance();
    end
    drive(1'b0, 32'h0, 1'b0);
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL still_full: in_ready=%b, want 0", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      vectors++;
      if (out_valid !== 1'b1 || out_rd !== 5'(i + 8)) begin
        errors++;
        $display("FAIL drain[%0d]: valid=%b rd=%0d, want 1 %0d", i, out_valid, out_rd, i + 8);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h03 | (32'(i + 1) << 7), 1'b0);
      advance();
    end
    apply_reset(1'b1);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {alu_count, load_count, illegal_count} !== 48'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b ready=%b counts=%0d/%0d/%0d, want 0 1 0/0/0",
               out_valid, in_ready, alu_count, load_count, illegal_count);
    end
    drive(1'b1, 32'h00000F13, 1'b0);
    advance();
    drive(1'b0, 32'h0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_rd !== 5'd30) begin
      errors++;
      $display("FAIL post_reset_push: valid=%b rd=%0d, want 1 30", out_valid, out_rd);
    end
    advance();
    drive(1'b0, 32'h0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_stale: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    ent_t e;
    bit v, r;
    int k;
    for (int c = 0; c < 400; c++) begin
      w = $urandom;
      k = $urandom_range(0, 3);
      if (k < 2) w[6:0] = 7'h13;
      if (k == 1) begin
        w[14:12] = $urandom_range(0, 1) ? 3'd1 : 3'd5;
        case ($urandom_range(0, 2))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          default: ;
        endcase
      end
      if (k == 2) w[6:0] = 7'h03;
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 2) != 0;
      drive(v, w, r);
      vectors++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < DEPTH || r)) begin
        errors++;
        $display("FAIL rnd_hs[%0d]: valid=%b ready=%b, want %b %b", c, out_valid, in_ready, q.size() != 0, q.size() < DEPTH || r);
      end
      if (q.size() != 0) begin
        e = q[0];
        vectors++;
        if ({out_is_alu, out_is_load, out_illegal, out_rd, out_rs1, out_funct3, out_imm} !==
            {e.alu, e.ld, e.ill, e.rd, e.rs1, e.f3, e.imm}) begin
          errors++;
          $display("FAIL rnd_head[%0d]: got alu=%b ld=%b ill=%b rd=%0d rs1=%0d f3=%0d imm=%h want %b %b %b %0d %0d %0d %h",
                   c, out_is_alu, out_is_load, out_illegal, out_rd, out_rs1, out_funct3, out_imm,
                   e.alu, e.ld, e.ill, e.rd, e.rs1, e.f3, e.imm);
        end
      end
      vectors++;
      if ({alu_count, load_count, illegal_count} !== {16'(m_alu), 16'(m_ld), 16'(m_ill)}) begin
        errors++;
        $display("FAIL rnd_counts[%0d]: %0d/%0d/%0d, want %0d/%0d/%0d", c, alu_count, load_count, illegal_count, m_alu, m_ld, m_ill);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_shift();
    test_illegal_opcodes();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
